issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, single clock (rising edge).
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port rdy, input, 1, global enable; low freezes all state.
REQ-005 SHALL have port flush, input, 1, discard all entries (redirect).
REQ-006 SHALL have ports dec_valid (input, 1) and dec_ready (output, 1), decoder enqueue handshake.
REQ-007 SHALL have inputs dec_is_vec 1, dec_type 2, dec_name 6, dec_rd 5, dec_pc 32, dec_imm 32: the entry payload.
REQ-008 SHALL have ports ins_rdy (input, 1), forward stage can accept, and bubble (input, 1), forward stage issued a MEM op.
REQ-009 SHALL have output issue_rdy, 1, head entry valid and issued this cycle.
REQ-010 SHALL have outputs is_vec 1, type 2, name 6, rd 5, pc 32, imm 32, the head entry payload.

Function
REQ-011 SHALL store entries in a circular buffer with head/tail pointers of log2(DEPTH) bits wrapping DEPTH-1 -> 0, plus a count of log2(DEPTH)+1 bits.
REQ-012 SHALL drive dec_ready = !full && !flush; full when count == DEPTH, even if a dequeue occurs in the same cycle.
REQ-013 SHALL enqueue at the tail on a clock edge with dec_valid && dec_ready && rdy.
REQ-014 SHALL drive issue_rdy = !empty && ins_rdy && !bubble_q && !flush, combinationally.
REQ-015 SHALL drive payload outputs combinationally from the head entry; they are don't-care while issue_rdy is 0.
REQ-016 SHALL advance head on every clock edge with issue_rdy && rdy; the forward stage accepts unconditionally when issue_rdy is high.
REQ-017 SHALL register bubble into bubble_q each enabled cycle, blocking issue for exactly one cycle after a MEM issue.
REQ-018 SHALL update count by +1, -1 or 0 on simultaneous enqueue and dequeue; count never over- or underflows.
REQ-019 SHALL, on flush, zero head, tail, count and bubble_q at the next edge; flush wins over an enqueue in the same cycle.
REQ-020 SHALL make an enqueued entry issuable no earlier than the next cycle (one-cycle latency) without bypass.
REQ-021 SHALL leave all state unchanged while rdy is low; issue_rdy still reflects current state.

Reset
REQ-022 SHALL, while rst is high, asynchronously clear head, tail, count and bubble_q to 0.
REQ-023 SHALL hold issue_rdy = 0 and dec_ready = 1 after reset; payload outputs are unspecified.
REQ-024 SHALL discard all in-flight entries and restart empty when reset is asserted mid-operation.

Configuration
REQ-025 SHALL, when ISSUE_BYPASS_EN is defined, present decoder inputs directly on the payload outputs with issue_rdy = dec_valid && ins_rdy && !bubble_q && !flush when the queue is empty; a bypassed entry is not written.
REQ-026 SHALL, without ISSUE_BYPASS_EN, have no combinational path from dec_* to the issue outputs.

Structure
REQ-027 SHALL take the type encodings (including MEM) and field widths from the shared constants file const.v.
REQ-028 SHALL define the 78-bit entry layout (is_vec, type, name, rd, pc, imm) as constants in that shared file.
REQ-029 SHALL implement storage in one sub-module, iq_ram: DEPTH x 78, single write port, asynchronous read port.

Verification
REQ-030 SHALL show: enqueue pc 0x1000 at cycle 0 with ins_rdy=1 -> issue_rdy=1 and pc=0x1000 at cycle 1; empty at cycle 2.
REQ-031 SHALL show: 8 enqueues with ins_rdy=0 -> dec_ready=0 after the 8th; then ins_rdy=1 drains pc order 0x0,0x4..0x1C, one per cycle.
REQ-032 SHALL show: head is a MEM entry with bubble=1 on its issue cycle -> issue_rdy=0 on the next cycle, the following entry issues one cycle later.
REQ-033 SHALL show: 5 entries queued, flush together with dec_valid=1 -> count=0 and issue_rdy=0 next cycle; the flush-cycle entry is dropped.
REQ-034 SHALL show: rst pulsed asynchronously mid-cycle with 3 entries queued -> issue_rdy=0 immediately, dec_ready=1.
REQ-035 SHALL show: with ISSUE_BYPASS_EN, empty queue, dec_valid=1, dec_pc=0x2000 -> issue_rdy=1 and pc=0x2000 in the same cycle, count stays 0.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared issue-queue constants: op type encodings, field widths and the 78-bit entry layout.
package issue_queue_pkg;

  localparam int TYPE_W  = 2;
  localparam int NAME_W  = 6;
  localparam int RD_W    = 5;
  localparam int PC_W    = 32;
  localparam int IMM_W   = 32;
  localparam int ENTRY_W = 1 + TYPE_W + NAME_W + RD_W + PC_W + IMM_W;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_ALU = 2'd0,
    TYPE_MEM = 2'd1,
    TYPE_BR  = 2'd2,
    TYPE_VEC = 2'd3
  } iq_type_e;

  // Packed MSB-first: is_vec, type, name, rd, pc, imm
  typedef struct packed {
    logic              is_vec;
    iq_type_e          op_type;
    logic [NAME_W-1:0] name;
    logic [RD_W-1:0]   rd;
    logic [PC_W-1:0]   pc;
    logic [IMM_W-1:0]  imm;
  } entry_t;

endpackage

// File: rtl/issue_queue_iq_ram.sv
// Entry storage for the issue queue: DEPTH x 78 bits, one synchronous write port, async read.
module iq_ram
  import issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/issue_queue.sv
// Decoder-to-issue circular queue with MEM bubble and flush.
// Optional ISSUE_BYPASS_EN: decoder inputs feed the issue outputs directly when the queue is empty.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic              dec_is_vec,
  input  logic [TYPE_W-1:0] dec_type,
  input  logic [NAME_W-1:0] dec_name,
  input  logic [RD_W-1:0]   dec_rd,
  input  logic [PC_W-1:0]   dec_pc,
  input  logic [IMM_W-1:0]  dec_imm,
  input  logic              ins_rdy,
  input  logic              bubble,
  output logic              issue_rdy,
  output logic              is_vec,
  output logic [TYPE_W-1:0] op_type,
  output logic [NAME_W-1:0] name,
  output logic [RD_W-1:0]   rd,
  output logic [PC_W-1:0]   pc,
  output logic [IMM_W-1:0]  imm
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0]   count;
  logic              bubble_q;
  logic              full, empty, enq, deq;
  entry_t            dec_entry, head_entry, issue_entry;

  assign full      = (count == (ADDR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign dec_ready = !full && !flush;

  assign dec_entry = '{is_vec:  dec_is_vec,
                       op_type: iq_type_e'(dec_type),
                       name:    dec_name,
                       rd:      dec_rd,
                       pc:      dec_pc,
                       imm:     dec_imm};

  iq_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdata (dec_entry),
    .raddr (head),
    .rdata (head_entry)
  );

`ifdef ISSUE_BYPASS_EN
  always_comb begin
    issue_entry = head_entry;
    issue_rdy   = !empty && ins_rdy && !bubble_q && !flush;
    if (empty) begin
      issue_entry = dec_entry;
      issue_rdy   = dec_valid && ins_rdy && !bubble_q && !flush;
    end
  end

  // An entry consumed through the bypass never occupies a slot
  assign enq = dec_valid && dec_ready && rdy && !(empty && issue_rdy);
`else
  assign issue_entry = head_entry;
  assign issue_rdy   = !empty && ins_rdy && !bubble_q && !flush;
  assign enq         = dec_valid && dec_ready && rdy;
`endif

  assign deq = issue_rdy && rdy && !empty;

  assign is_vec  = issue_entry.is_vec;
  assign op_type = issue_entry.op_type;
  assign name    = issue_entry.name;
  assign rd      = issue_entry.rd;
  assign pc      = issue_entry.pc;
  assign imm     = issue_entry.imm;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      bubble_q <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        bubble_q <= 1'b0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        count    <= count + (ADDR_W+1)'(enq) - (ADDR_W+1)'(deq);
        bubble_q <= bubble;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected entries queued on enqueue, compared on issue.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic              clk = 1'b0;
  logic              rst, rdy, flush, dec_valid, dec_ready;
  logic              dec_is_vec;
  logic [TYPE_W-1:0] dec_type;
  logic [NAME_W-1:0] dec_name;
  logic [RD_W-1:0]   dec_rd;
  logic [PC_W-1:0]   dec_pc;
  logic [IMM_W-1:0]  dec_imm;
  logic              ins_rdy, bubble, issue_rdy, is_vec;
  logic [TYPE_W-1:0] op_type;
  logic [NAME_W-1:0] name;
  logic [RD_W-1:0]   rd;
  logic [PC_W-1:0]   pc;
  logic [IMM_W-1:0]  imm;

  int     n_cmp = 0;
  int     n_bad = 0;
  entry_t sb[$];
  entry_t exp_e, obs_e;

  issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_is_vec(dec_is_vec), .dec_type(dec_type), .dec_name(dec_name),
    .dec_rd(dec_rd), .dec_pc(dec_pc), .dec_imm(dec_imm),
    .ins_rdy(ins_rdy), .bubble(bubble), .issue_rdy(issue_rdy),
    .is_vec(is_vec), .op_type(op_type), .name(name), .rd(rd), .pc(pc), .imm(imm)
  );

  always #5 clk = ~clk;

  assign obs_e = '{is_vec: is_vec, op_type: iq_type_e'(op_type), name: name,
                   rd: rd, pc: pc, imm: imm};

  function automatic entry_t mk(input logic [31:0] p, input iq_type_e t);
    entry_t e;
    e.is_vec  = p[2];
    e.op_type = t;
    e.name    = p[8:3];
    e.rd      = p[6:2] ^ 5'h15;
    e.pc      = p;
    e.imm     = ~p;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input entry_t e);
    dec_valid  = v;
    dec_is_vec = e.is_vec;
    dec_type   = e.op_type;
    dec_name   = e.name;
    dec_rd     = e.rd;
    dec_pc     = e.pc;
    dec_imm    = e.imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; ins_rdy = 1'b0; bubble = 1'b0;
    drive(1'b0, mk(32'h0, TYPE_ALU));
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_issue_rdy: got %b want 0", issue_rdy); end
    n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL reset_dec_ready: got %b want 1", dec_ready); end
    n_cmp++; if (dut.count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", dut.count); end
  endtask

  task automatic test_single();
    tick();
    ins_rdy = 1'b1;
    drive(1'b1, mk(32'h1000, TYPE_ALU));
    sb.push_back(mk(32'h1000, TYPE_ALU));
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL single_c0_no_bypass: got %b want 0", issue_rdy); end
    tick();
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    exp_e = sb.pop_front();
    n_cmp++; if (issue_rdy !== 1'b1) begin n_bad++; $display("FAIL single_c1_issue: got %b want 1", issue_rdy); end
    n_cmp++; if (obs_e !== exp_e) begin n_bad++; $display("FAIL single_c1_entry: got %h want %h", obs_e, exp_e); end
    tick();
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL single_c2_empty: got %b want 0", issue_rdy); end
  endtask

  task automatic test_fill_drain();
    ins_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(32'(i * 4), TYPE_ALU));
      sb.push_back(mk(32'(i * 4), TYPE_ALU));
      #1;
      n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b want 1", i, dec_ready); end
      tick();
    end
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", dec_ready); end
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL full_hold: got %b want 0", issue_rdy); end
    ins_rdy = 1'b1;
    drive(1'b1, mk(32'hDEAD, TYPE_ALU));
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_e = sb.pop_front();
      if (i == 0) begin
        n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL full_deq_ready: got %b want 0", dec_ready); end
      end
      n_cmp++; if (issue_rdy !== 1'b1) begin n_bad++; $display("FAIL drain_issue[%0d]: got %b want 1", i, issue_rdy); end
      n_cmp++; if (obs_e !== exp_e) begin n_bad++; $display("FAIL drain_entry[%0d]: got %h want %h", i, obs_e, exp_e); end
      tick();
      drive(1'b0, mk(32'h0, TYPE_ALU));
    end
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", issue_rdy); end
  endtask

  task automatic test_mem_bubble();
    ins_rdy = 1'b0;
    drive(1'b1, mk(32'h4000, TYPE_MEM)); sb.push_back(mk(32'h4000, TYPE_MEM)); tick();
    drive(1'b1, mk(32'h4004, TYPE_ALU)); sb.push_back(mk(32'h4004, TYPE_ALU)); tick();
    drive(1'b0, mk(32'h0, TYPE_ALU));
    ins_rdy = 1'b1; bubble = 1'b1;
    #1;
    exp_e = sb.pop_front();
    n_cmp++; if (issue_rdy !== 1'b1) begin n_bad++; $display("FAIL mem_issue: got %b want 1", issue_rdy); end
    n_cmp++; if (obs_e !== exp_e) begin n_bad++; $display("FAIL mem_entry: got %h want %h", obs_e, exp_e); end
    tick();
    bubble = 1'b0;
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL mem_bubble: got %b want 0", issue_rdy); end
    tick();
    #1;
    exp_e = sb.pop_front();
    n_cmp++; if (issue_rdy !== 1'b1) begin n_bad++; $display("FAIL after_bubble_issue: got %b want 1", issue_rdy); end
    n_cmp++; if (obs_e !== exp_e) begin n_bad++; $display("FAIL after_bubble_entry: got %h want %h", obs_e, exp_e); end
    tick();
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL mem_empty: got %b want 0", issue_rdy); end
  endtask

  task automatic test_flush();
    ins_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(32'h5000 + 32'(i * 4), TYPE_ALU));
      tick();
    end
    flush = 1'b1;
    drive(1'b1, mk(32'h0F00, TYPE_ALU));
    #1;
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", dec_ready); end
    tick();
    flush = 1'b0; ins_rdy = 1'b1;
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    n_cmp++; if (dut.count !== 4'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", dut.count); end
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL flush_issue: got %b want 0", issue_rdy); end
    tick();
    drive(1'b1, mk(32'h6000, TYPE_BR)); sb.push_back(mk(32'h6000, TYPE_BR));
    tick();
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    exp_e = sb.pop_front();
    n_cmp++; if (obs_e !== exp_e || issue_rdy !== 1'b1) begin n_bad++; $display("FAIL post_flush_entry: got %h/%b want %h/1", obs_e, issue_rdy, exp_e); end
    tick();
  endtask

  task automatic test_async_reset();
    ins_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(32'h7000 + 32'(i * 4), TYPE_VEC));
      tick();
    end
    drive(1'b0, mk(32'h0, TYPE_ALU));
    ins_rdy = 1'b1;
    #1;
    n_cmp++; if (issue_rdy !== 1'b1) begin n_bad++; $display("FAIL pre_rst_issue: got %b want 1", issue_rdy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL async_rst_issue: got %b want 0", issue_rdy); end
    n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready: got %b want 1", dec_ready); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (dut.count !== 4'd0 || issue_rdy !== 1'b0) begin n_bad++; $display("FAIL post_rst_state: got %0d/%b want 0/0", dut.count, issue_rdy); end
  endtask

  task automatic test_rdy_freeze();
    ins_rdy = 1'b0;
    drive(1'b1, mk(32'h8000, TYPE_ALU)); sb.push_back(mk(32'h8000, TYPE_ALU)); tick();
    drive(1'b1, mk(32'h8004, TYPE_MEM)); sb.push_back(mk(32'h8004, TYPE_MEM)); tick();
    rdy = 1'b0; ins_rdy = 1'b1; bubble = 1'b1;
    drive(1'b1, mk(32'h8FFC, TYPE_ALU));
    repeat (3) tick();
    exp_e = sb[0];
    n_cmp++; if (issue_rdy !== 1'b1 || obs_e !== exp_e) begin n_bad++; $display("FAIL freeze_head: got %h/%b want %h/1", obs_e, issue_rdy, exp_e); end
    n_cmp++; if (dut.count !== 4'd2) begin n_bad++; $display("FAIL freeze_count: got %0d want 2", dut.count); end
    rdy = 1'b1; bubble = 1'b0;
    drive(1'b0, mk(32'h0, TYPE_ALU));
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_e = sb.pop_front();
      n_cmp++; if (issue_rdy !== 1'b1 || obs_e !== exp_e) begin n_bad++; $display("FAIL unfreeze[%0d]: got %h/%b want %h/1", i, obs_e, issue_rdy, exp_e); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    ins_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(32'h3000 + 32'(i * 4), TYPE_ALU));
      sb.push_back(mk(32'h3000 + 32'(i * 4), TYPE_ALU));
      #1;
      if (i > 0) begin
        exp_e = sb.pop_front();
        n_cmp++; if (issue_rdy !== 1'b1 || obs_e !== exp_e) begin n_bad++; $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, obs_e, issue_rdy, exp_e); end
      end
      tick();
    end
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    exp_e = sb.pop_front();
    n_cmp++; if (issue_rdy !== 1'b1 || obs_e !== exp_e) begin n_bad++; $display("FAIL b2b_last: got %h/%b want %h/1", obs_e, issue_rdy, exp_e); end
    tick();
    #1;
    n_cmp++; if (issue_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", issue_rdy); end
  endtask

`ifdef ISSUE_BYPASS_EN
  task automatic test_bypass();
    ins_rdy = 1'b1;
    drive(1'b1, mk(32'h2000, TYPE_ALU));
    #1;
    exp_e = mk(32'h2000, TYPE_ALU);
    n_cmp++; if (issue_rdy !== 1'b1 || obs_e !== exp_e) begin n_bad++; $display("FAIL bypass: got %h/%b want %h/1", obs_e, issue_rdy, exp_e); end
    tick();
    drive(1'b0, mk(32'h0, TYPE_ALU));
    #1;
    n_cmp++; if (dut.count !== 4'd0 || issue_rdy !== 1'b0) begin n_bad++; $display("FAIL bypass_count: got %0d/%b want 0/0", dut.count, issue_rdy); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef ISSUE_BYPASS_EN
    test_bypass();
`else
    test_single();
`endif
    test_fill_drain();
    test_mem_bubble();
    test_flush();
    test_rdy_freeze();
`ifndef ISSUE_BYPASS_EN
    test_back_to_back();
`endif
    test_async_reset();
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
